// File: rtl/cgra_pkt_dma_ctrl_pkg.sv
// cgra_pkt_dma_ctrl_pkg: widths, FSM state types and container beat/address helpers shared by the packet DMA
package cgra_pkt_dma_ctrl_pkg;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int LEN_W = 16;
    localparam int CGRA_PKT_W = 185;
    localparam int PKT_BYTES = 24;
    localparam int BEATS = 3;
    localparam int CONT_W = DATA_W * BEATS;
    typedef enum logic [1:0] {RX_IDLE, RX_RD, RX_SEND, RX_DONE} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_WR, TX_DONE} tx_state_t;
    function automatic logic [DATA_W-1:0] beat_slice(input logic [CONT_W-1:0] c, input logic [1:0] b);
        return c[DATA_W*b +: DATA_W];
    endfunction
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] idx, input logic [1:0] b);
        return base + ADDR_W'(idx) * ADDR_W'(PKT_BYTES) + ADDR_W'({b, 3'b000});
    endfunction
endpackage

// File: rtl/dma_mem_arb.sv
// dma_mem_arb: round-robin beat arbiter (rx read / tx write requesters -> shared mem_req port) with single outstanding-read tracking
module dma_mem_arb
    import cgra_pkt_dma_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_req,
    input  logic [ADDR_W-1:0] rx_addr,
    input  logic              tx_req,
    input  logic [ADDR_W-1:0] tx_addr,
    input  logic [DATA_W-1:0] tx_wdata,
    output logic              rx_grant,
    output logic              tx_grant,
    output logic              rx_resp,
    output logic              mem_req_val,
    input  logic              mem_req_rdy,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_val
);
    logic rd_out, last_rx, pend, pend_rx, rx_ok, tx_ok, sel_rx;
    assign rx_resp = mem_resp_val & rd_out;
    assign rx_ok = rx_req & (~rd_out | mem_resp_val);
    assign tx_ok = tx_req & ~rd_out;
    assign sel_rx = pend ? pend_rx : rx_ok & (~tx_ok | ~last_rx);
    assign mem_req_val = sel_rx ? rx_ok : tx_ok;
    assign mem_req_we = mem_req_val & ~sel_rx;
    assign mem_req_addr = ~mem_req_val ? '0 : sel_rx ? rx_addr : tx_addr;
    assign mem_req_wdata = mem_req_we ? tx_wdata : '0;
    assign rx_grant = mem_req_val & mem_req_rdy & sel_rx;
    assign tx_grant = mem_req_val & mem_req_rdy & ~sel_rx;
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_out <= 1'b0;
            last_rx <= 1'b0;
            pend <= 1'b0;
            pend_rx <= 1'b0;
        end else begin
            rd_out <= rx_grant | (rd_out & ~mem_resp_val);
            last_rx <= (rx_grant | tx_grant) ? rx_grant : last_rx;
            pend <= mem_req_val & ~mem_req_rdy;
            pend_rx <= sel_rx;
        end
    end
endmodule

// File: rtl/cgra_pkt_dma_ctrl.sv
// cgra_pkt_dma_ctrl: duplex packet DMA (cfg_* start/src/dst/len in, stat_* out, shared mem_req/mem_resp port, send_to_cgra/recv_from_cgra packet ports)
module cgra_pkt_dma_ctrl
    import cgra_pkt_dma_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     cfg_src_rx,
    input  logic [LEN_W-1:0]      cfg_len_rx,
    input  logic                  cfg_start_rx,
    input  logic [ADDR_W-1:0]     cfg_dst_tx,
    input  logic [LEN_W-1:0]      cfg_len_tx,
    input  logic                  cfg_start_tx,
    output logic                  stat_busy_rx,
    output logic                  stat_busy_tx,
    output logic                  stat_done_rx,
    output logic                  stat_done_tx,
    output logic                  stat_err,
    output logic                  mem_req_val,
    input  logic                  mem_req_rdy,
    output logic                  mem_req_we,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic [DATA_W-1:0]     mem_req_wdata,
    input  logic                  mem_resp_val,
    input  logic [DATA_W-1:0]     mem_resp_rdata,
    output logic                  send_to_cgra__val,
    input  logic                  send_to_cgra__rdy,
    output logic [CGRA_PKT_W-1:0] send_to_cgra__msg,
    input  logic                  recv_from_cgra__val,
    output logic                  recv_from_cgra__rdy,
    input  logic [CGRA_PKT_W-1:0] recv_from_cgra__msg
);
    rx_state_t rx_st;
    tx_state_t tx_st;
    logic [ADDR_W-1:0] rx_base, tx_base;
    logic [LEN_W-1:0] rx_len, tx_len, rx_idx, tx_idx;
    logic [1:0] rx_iss, rx_rcv, tx_beat;
    logic [CONT_W-1:0] rx_buf, tx_buf;
    logic rx_grant, tx_grant, rx_resp, rx_go, tx_go, rx_bad, tx_bad, unused_pad;
    assign rx_go = cfg_start_rx & (rx_st == RX_IDLE) & (cfg_src_rx[2:0] == 3'b000);
    assign rx_bad = cfg_start_rx & (rx_st == RX_IDLE) & (cfg_src_rx[2:0] != 3'b000);
    assign tx_go = cfg_start_tx & (tx_st == TX_IDLE) & (cfg_dst_tx[2:0] == 3'b000);
    assign tx_bad = cfg_start_tx & (tx_st == TX_IDLE) & (cfg_dst_tx[2:0] != 3'b000);
    assign send_to_cgra__val = rx_st == RX_SEND;
    assign send_to_cgra__msg = rx_buf[CGRA_PKT_W-1:0];
    assign recv_from_cgra__rdy = tx_st == TX_WAIT;
    assign unused_pad = ^rx_buf[CONT_W-1:CGRA_PKT_W];
    dma_mem_arb u_arb (
        .clk(clk),
        .reset(reset),
        .rx_req((rx_st == RX_RD) & (rx_iss != 2'(BEATS))),
        .rx_addr(beat_addr(rx_base, rx_idx, rx_iss)),
        .tx_req(tx_st == TX_WR),
        .tx_addr(beat_addr(tx_base, tx_idx, tx_beat)),
        .tx_wdata(beat_slice(tx_buf, tx_beat)),
        .rx_grant(rx_grant),
        .tx_grant(tx_grant),
        .rx_resp(rx_resp),
        .mem_req_val(mem_req_val),
        .mem_req_rdy(mem_req_rdy),
        .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_resp_val(mem_resp_val)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_st <= RX_IDLE;
            rx_base <= '0;
            rx_len <= '0;
            rx_idx <= '0;
            rx_iss <= '0;
            rx_rcv <= '0;
            rx_buf <= '0;
            stat_busy_rx <= 1'b0;
            stat_done_rx <= 1'b0;
        end else begin
            case (rx_st)
                RX_IDLE: if (rx_go) begin
                    rx_base <= cfg_src_rx;
                    rx_len <= cfg_len_rx;
                    rx_idx <= '0;
                    rx_iss <= '0;
                    rx_rcv <= '0;
                    stat_done_rx <= cfg_len_rx == '0;
                    stat_busy_rx <= cfg_len_rx != '0;
                    rx_st <= (cfg_len_rx == '0) ? RX_IDLE : RX_RD;
                end
                RX_RD: begin
                    if (rx_grant) rx_iss <= rx_iss + 2'd1;
                    if (rx_resp) begin
                        rx_buf[DATA_W*rx_rcv +: DATA_W] <= mem_resp_rdata;
                        rx_rcv <= rx_rcv + 2'd1;
                        if (rx_rcv == 2'(BEATS-1)) rx_st <= RX_SEND;
                    end
                end
                RX_SEND: if (send_to_cgra__rdy) begin
                    rx_idx <= rx_idx + LEN_W'(1);
                    rx_iss <= '0;
                    rx_rcv <= '0;
                    rx_st <= (rx_idx + LEN_W'(1) == rx_len) ? RX_DONE : RX_RD;
                end
                default: begin
                    stat_done_rx <= 1'b1;
                    stat_busy_rx <= 1'b0;
                    rx_st <= RX_IDLE;
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st <= TX_IDLE;
            tx_base <= '0;
            tx_len <= '0;
            tx_idx <= '0;
            tx_beat <= '0;
            tx_buf <= '0;
            stat_busy_tx <= 1'b0;
            stat_done_tx <= 1'b0;
        end else begin
            case (tx_st)
                TX_IDLE: if (tx_go) begin
                    tx_base <= cfg_dst_tx;
                    tx_len <= cfg_len_tx;
                    tx_idx <= '0;
                    stat_done_tx <= cfg_len_tx == '0;
                    stat_busy_tx <= cfg_len_tx != '0;
                    tx_st <= (cfg_len_tx == '0) ? TX_IDLE : TX_WAIT;
                end
                TX_WAIT: if (recv_from_cgra__val) begin
                    tx_buf <= CONT_W'(recv_from_cgra__msg);
                    tx_beat <= '0;
                    tx_st <= TX_WR;
                end
                TX_WR: if (tx_grant) begin
                    tx_beat <= tx_beat + 2'd1;
                    if (tx_beat == 2'(BEATS-1)) begin
                        tx_idx <= tx_idx + LEN_W'(1);
                        tx_st <= (tx_idx + LEN_W'(1) == tx_len) ? TX_DONE : TX_WAIT;
                    end
                end
                default: begin
                    stat_done_tx <= 1'b1;
                    stat_busy_tx <= 1'b0;
                    tx_st <= TX_IDLE;
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) stat_err <= 1'b0;
        else stat_err <= (rx_bad | tx_bad) ? 1'b1 : (rx_go | tx_go) ? 1'b0 : stat_err;
    end
endmodule

// File: tb/tb_cgra_pkt_dma_ctrl.sv
// tb_cgra_pkt_dma_ctrl: directed-vector bench for the duplex packet DMA with an SRAM model and CGRA packet endpoints
module tb_cgra_pkt_dma_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [63:0] cfg_src_rx = '0, cfg_dst_tx = '0;
    logic [15:0] cfg_len_rx = '0, cfg_len_tx = '0;
    logic cfg_start_rx = 1'b0, cfg_start_tx = 1'b0;
    logic stat_busy_rx, stat_busy_tx, stat_done_rx, stat_done_tx, stat_err;
    logic mem_req_val, mem_req_rdy, mem_req_we;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic mem_resp_val;
    logic [63:0] mem_resp_rdata;
    logic send_val, recv_rdy;
    logic send_rdy = 1'b1, recv_val = 1'b0;
    logic [184:0] send_msg;
    logic [184:0] recv_msg = '0;
    int n_vec = 0, n_err = 0, n_rd = 0, n_wr = 0;
    bit rdy_rand = 1'b0;
    logic [63:0] mem [logic [63:0]];
    logic [184:0] rx_got [$];
    logic we_log [$];

    cgra_pkt_dma_ctrl dut (
        .clk(clk), .reset(reset),
        .cfg_src_rx(cfg_src_rx), .cfg_len_rx(cfg_len_rx), .cfg_start_rx(cfg_start_rx),
        .cfg_dst_tx(cfg_dst_tx), .cfg_len_tx(cfg_len_tx), .cfg_start_tx(cfg_start_tx),
        .stat_busy_rx(stat_busy_rx), .stat_busy_tx(stat_busy_tx),
        .stat_done_rx(stat_done_rx), .stat_done_tx(stat_done_tx), .stat_err(stat_err),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_val(mem_resp_val), .mem_resp_rdata(mem_resp_rdata),
        .send_to_cgra__val(send_val), .send_to_cgra__rdy(send_rdy), .send_to_cgra__msg(send_msg),
        .recv_from_cgra__val(recv_val), .recv_from_cgra__rdy(recv_rdy), .recv_from_cgra__msg(recv_msg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) mem_req_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;

    always @(posedge clk) begin
        mem_resp_val <= 1'b0;
        if (mem_req_val && mem_req_rdy) begin
            we_log.push_back(mem_req_we);
            if (mem_req_we) begin
                mem[mem_req_addr] = mem_req_wdata;
                n_wr++;
            end else begin
                mem_resp_val <= 1'b1;
                mem_resp_rdata <= mem.exists(mem_req_addr) ? mem[mem_req_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
                n_rd++;
            end
        end
        if (send_val && send_rdy) rx_got.push_back(send_msg);
    end

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [191:0] cont(input int i);
        return {64'hF0F0_0000_0000_0000 | 64'(i), 64'h0123_4567_89AB_CDEF ^ 64'(i), 64'hCAFE_0000_0000_0000 + 64'(i)};
    endfunction

    function automatic logic [184:0] tpkt(input int i);
        return {57'h1_FFFF_0000_0000_00 | 57'(i), 64'h0123_4567_89AB_CDEF ^ 64'(i), 64'hDEAD_0000 + 64'(i)};
    endfunction

    function automatic logic [63:0] rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic start(input bit rx, input bit tx, input logic [63:0] src, input logic [63:0] dst,
                         input logic [15:0] lr, input logic [15:0] lt);
        @(negedge clk);
        cfg_src_rx = src; cfg_len_rx = lr; cfg_dst_tx = dst; cfg_len_tx = lt;
        cfg_start_rx = rx; cfg_start_tx = tx;
        @(negedge clk);
        cfg_start_rx = 1'b0; cfg_start_tx = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit rx);
        int k = 0;
        while (!(rx ? stat_done_rx : stat_done_tx) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(tag, rx ? stat_done_rx : stat_done_tx, 1);
        check({tag, "_busy"}, rx ? stat_busy_rx : stat_busy_tx, 0);
    endtask

    task automatic push(input logic [184:0] p);
        int k = 0;
        @(negedge clk);
        recv_val = 1'b1;
        recv_msg = p;
        while (!recv_rdy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("push_rdy", recv_rdy, 1);
        @(posedge clk);
        #1 recv_val = 1'b0;
    endtask

    task automatic check_rx(input string tag, input int first, input int n);
        logic [191:0] c;
        check({tag, "_count"}, rx_got.size(), n);
        for (int i = 0; i < n; i++) begin
            c = cont(first + i);
            check($sformatf("%s_pkt%0d", tag, i), rx_got.size() > i ? rx_got[i] : '1, c[184:0]);
        end
    endtask

    task automatic check_tx(input string tag, input logic [63:0] base, input int first);
        logic [191:0] c;
        for (int i = 0; i < 3; i++) begin
            c = {7'b0, tpkt(first + i)};
            for (int b = 0; b < 3; b++)
                check($sformatf("%s_mem%0d_%0d", tag, i, b), rd(base + 64'(24 * i + 8 * b)), c[64*b +: 64]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int first_send, r0, w0, sw, k;
        bit stable;
        logic [184:0] m0;
        logic [191:0] c;
        for (int i = 0; i < 3; i++) begin
            c = cont(i);
            for (int b = 0; b < 3; b++) mem[64'h1000 + 64'(24 * i + 8 * b)] = c[64*b +: 64];
        end
        repeat (3) @(negedge clk);
        check("reset_state", {mem_req_val, mem_req_we, mem_req_addr, mem_req_wdata, send_val, recv_rdy,
                              stat_busy_rx, stat_busy_tx, stat_done_rx, stat_done_tx, stat_err}, 0);
        reset = 1'b0;

        // 1: RX of three containers, timing of first beats and first packet
        r0 = n_rd;
        first_send = -1;
        start(1, 0, 64'h1000, 0, 3, 0);
        check("t1_busy", stat_busy_rx, 1);
        for (k = 1; k <= 8; k++) begin
            if (k == 1) check("t1_req0", {mem_req_val, mem_req_we, mem_req_addr}, {2'b10, 64'h1000});
            if (k == 2) check("t1_req1", {mem_resp_val, mem_req_val, mem_req_addr}, {2'b11, 64'h1008});
            if (send_val && first_send < 0) first_send = k;
            @(negedge clk);
        end
        check("t1_first_send", first_send, 5);
        wait_done("t1_done", 1);
        check_rx("t1", 0, 3);
        check("t1_reads", n_rd - r0, 9);

        // 2: TX of three packets to 0x2000
        w0 = n_wr;
        start(0, 1, 0, 64'h2000, 0, 3);
        for (int i = 0; i < 3; i++) push(tpkt(i));
        wait_done("t2_done", 0);
        check_tx("t2", 64'h2000, 0);
        check("t2_writes", n_wr - w0, 9);

        // 3: both channels together with a stalling memory port
        rx_got.delete();
        we_log.delete();
        r0 = n_rd;
        w0 = n_wr;
        rdy_rand = 1'b1;
        start(1, 1, 64'h1000, 64'h3000, 3, 3);
        for (int i = 0; i < 3; i++) push(tpkt(10 + i));
        wait_done("t3_done_tx", 0);
        wait_done("t3_done_rx", 1);
        rdy_rand = 1'b0;
        check_rx("t3", 0, 3);
        check_tx("t3", 64'h3000, 10);
        check("t3_beats", {16'(n_rd - r0), 16'(n_wr - w0)}, {16'd9, 16'd9});
        sw = 0;
        for (int i = 1; i < we_log.size(); i++) if (we_log[i] != we_log[i-1]) sw++;
        check("t3_interleaved", sw >= 2, 1);

        // 4: misaligned starts and zero-length starts
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        r0 = n_rd + n_wr;
        start(1, 0, 64'h1004, 0, 3, 0);
        check("t4_err_rx", {stat_err, stat_busy_rx, stat_done_rx, mem_req_val}, 4'b1000);
        start(1, 0, 64'h1000, 0, 0, 0);
        check("t4_len0_rx", {stat_err, stat_busy_rx, stat_done_rx}, 3'b001);
        start(0, 1, 0, 64'h2002, 0, 3);
        check("t4_err_tx", {stat_err, stat_busy_tx, stat_done_tx, recv_rdy}, 4'b1000);
        start(0, 1, 0, 64'h2000, 0, 0);
        check("t4_len0_tx", {stat_err, stat_busy_tx, stat_done_tx, recv_rdy}, 4'b0010);
        repeat (3) @(negedge clk);
        check("t4_no_traffic", n_rd + n_wr - r0, 0);

        // 5: CGRA back-pressure, restart while busy is ignored
        rx_got.delete();
        send_rdy = 1'b0;
        start(1, 0, 64'h1000, 0, 2, 0);
        k = 0;
        while (!send_val && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t5_val", send_val, 1);
        m0 = send_msg;
        r0 = n_rd;
        c = cont(0);
        check("t5_msg", m0, c[184:0]);
        start(1, 0, 64'h1030, 0, 1, 0);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            stable &= send_val && (send_msg == m0) && !mem_req_val;
        end
        check("t5_stable", stable, 1);
        check("t5_no_reads", n_rd - r0, 0);
        check("t5_busy", {stat_busy_rx, stat_done_rx}, 2'b10);
        send_rdy = 1'b1;
        wait_done("t5_done", 1);
        check_rx("t5", 0, 2);

        // 6: reset while RX beat 1 is being requested
        rx_got.delete();
        start(1, 0, 64'h1000, 0, 3, 0);
        k = 0;
        while (!(mem_req_val && mem_req_addr == 64'h1008) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t6_beat1", {mem_req_val, mem_req_addr}, {1'b1, 64'h1008});
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_reset_out", {mem_req_val, mem_req_we, mem_req_addr, mem_req_wdata, send_val, recv_rdy,
                               stat_busy_rx, stat_busy_tx, stat_done_rx, stat_done_tx, stat_err}, 0);
        check("t6_late_resp", mem_resp_val, 1);
        @(negedge clk) reset = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_idle", {stat_busy_rx, send_val, mem_req_val, 8'(rx_got.size())}, 0);
        start(1, 0, 64'h1018, 0, 1, 0);
        wait_done("t6_done", 1);
        check_rx("t6", 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cgra_pkt_dma_ctrl.md
Name: cgra_pkt_dma_ctrl

Overview:
Duplex packet DMA controller between the shared SoC SRAM port and the CGRA packet interface.
- RX channel: reads 24-byte packet containers from SRAM at src and delivers 185-bit packets to the CGRA.
- TX channel: accepts 185-bit packets from the CGRA and writes them as 24-byte containers to SRAM at dst.
- One 64-bit memory request port is shared by both channels through an internal round-robin arbiter.
- Programmed by the MMIO register block (src/dst/len/start); completion is reported through done/busy/err status.

Parameters:
ADDR_W, 64, memory byte-address width
DATA_W, 64, memory beat width (8 bytes)
PKT_W, 185, CGRA packet width
BEATS, 3, beats per 24-byte container
LEN_W, 16, packet-count width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_src_rx  in  ADDR_W  RX source base address
cfg_len_rx  in  LEN_W  RX packet count
cfg_start_rx  in  1  RX one-cycle start strobe
cfg_dst_tx  in  ADDR_W  TX destination base address
cfg_len_tx  in  LEN_W  TX packet count
cfg_start_tx  in  1  TX one-cycle start strobe
stat_busy_rx / stat_busy_tx  out  1  channel active
stat_done_rx / stat_done_tx  out  1  sticky completion flag
stat_err  out  1  sticky misaligned-start error
mem_req_val  out  1  memory request valid
mem_req_rdy  in  1  memory accepts request
mem_req_we  out  1  1 = write, 0 = read
mem_req_addr  out  ADDR_W  byte address (8-aligned)
mem_req_wdata  out  DATA_W  write beat
mem_resp_val  in  1  read data valid (in order, latency >= 1)
mem_resp_rdata  in  DATA_W  read beat
send_to_cgra__val / __rdy  out / in  1  packet to CGRA
send_to_cgra__msg  out  PKT_W  packet
recv_from_cgra__val / __rdy  in / out  1  packet from CGRA
recv_from_cgra__msg  in  PKT_W  packet

Behaviour:
- Reset: all status outputs = 0, all val/rdy outputs = 0, mem_req_* = 0, both FSMs in IDLE, round-robin pointer favours RX, no read outstanding.
- Container format:
  - beat b (b = 0..2) carries container bits [64b +: 64] at byte address base + 24*i + 8*b.
  - Packet = container[184:0].
  - On TX writes, container[191:185] = 0.
- Start handling:
  - A start is accepted only in IDLE; a start while busy is ignored.
  - An accepted start clears that channel's done flag and sets busy.
  - If the base address has addr[2:0] != 0, the start is rejected: stat_err = 1, busy and done are unchanged.
  - stat_err clears on the next accepted, aligned start on either channel.
  - len = 0: done = 1 and busy = 0 in the cycle after the start, with no memory traffic.
- RX FSM: IDLE -> RD (issue beats 0..2, one read outstanding, capture beats into a 192-bit buffer) -> SEND (send_to_cgra__val = 1, msg held stable until rdy) -> RD for the next packet, or DONE when the count is reached.
  - DONE sets done = 1, busy = 0, then returns to IDLE.
  - The next beat's request may assert in the same cycle as the previous beat's response.
  - Uncontended, with rdy = 1 and read latency 1: start sampled at edge 0 gives req0 @1, resp0 + req1 @2, resp1 + req2 @3, resp2 @4, send val @5.
- TX FSM: IDLE -> WAIT (recv_from_cgra__rdy = 1) -> WR (three write beats after the handshake, rdy = 0 throughout) -> WAIT or DONE.
  - Writes complete on mem_req_val & mem_req_rdy; there is no response.
- Arbiter:
  - Granularity is one beat.
  - While a read is outstanding, no new request of either type issues, except the next RX read in the response cycle.
  - When both channels request, the grant goes to the channel not granted last; the pointer updates on each accepted request.
  - Request fields are held stable while val = 1 and rdy = 0.
- Counters:
  - Packet index is LEN_W bits; addresses are computed as base + 24*index + 8*beat, modulo 2^ADDR_W (wrap-around is allowed).
- Error handling: mem_resp_val with no read outstanding is dropped.
- Reset mid-operation: abort immediately to the reset state; an in-flight read response after reset is dropped.

Decomposition:
- Shared package: CGRA_PKT_W = 185, PKT_BYTES = 24, BEATS = 3, and the beat/container slice helper function.
- One sub-module: dma_mem_arb (two-requester round-robin beat arbiter with outstanding-read tracking).
- Both FSMs live in the top module.

Test Plan:
1. Preload 3 containers at 0x1000; RX start with src = 0x1000, len = 3; CGRA rdy = 1 -> 3 packets out equal to container[184:0] in order; first send val at cycle 5; stat_done_rx = 1.
2. TX start with dst = 0x2000, len = 3; drive 3 packets 0xDEAD0000 + i -> SRAM[0x2000 + 24i .. +23] holds each packet with bits [191:185] = 0; stat_done_tx = 1.
3. Start RX and TX simultaneously with mem_req_rdy toggling 50% -> grants alternate under contention; both done; data as in scenarios 1 and 2; no beat lost or duplicated.
4. Start with src = 0x1004 -> stat_err = 1, busy = 0, no mem_req; a subsequent valid start clears stat_err. Start with len = 0 -> done next cycle, no traffic.
5. Hold send_to_cgra__rdy = 0 for 10 cycles -> msg stable and no further reads issued. Re-start while busy -> ignored.
6. Assert reset during RX beat 1 -> all outputs 0 in the next cycle; a late mem_resp_val is ignored; a fresh start runs cleanly.
